// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: serialises requester writes to one shared register as grant, write, then read-back check.
// Define SHARED_REG_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module shared_reg_arbiter #(
    parameter int                NUM_REQ = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]          reg_q,
    output logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [15:0]                commit_cnt,
    output logic                       busy,
    output logic                       ERROR
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, CHECK} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, ptr_nxt, arb_ptr, idx, win_id;
    logic [ID_W-1:0]     cap_id_q, cap_id_d, last_id_q, last_id_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d, reg_d;
    logic [DATA_W-1:0]   lane [NUM_REQ];
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d, win_vld, load;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = wdata[i*DATA_W +: DATA_W];
    end

`ifdef SHARED_REG_FIXED_PRIO_EN
    assign ptr_nxt = '0;
    assign arb_ptr = ptr_q;
`else
    // Explicit wrap so non-power-of-two NUM_REQ never selects a missing lane.
    assign ptr_nxt = (cap_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cap_id_q + 1'b1;
    assign arb_ptr = (state_q == CHECK) ? ptr_nxt : ptr_q;
`endif

    // Scan downward so the last hit is the first requester at or after arb_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(arb_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    assign load = win_vld && (state_q == IDLE || state_q == CHECK);

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        reg_d      = reg_q;
        cap_id_d   = cap_id_q;
        cap_data_d = cap_data_q;
        ptr_d      = ptr_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE:  state_d = load ? GRANT : IDLE;
            GRANT: state_d = WRITE;
            WRITE: begin
                reg_d   = cap_data_q;
                state_d = CHECK;
            end
            CHECK: begin
                err_d     = err_q | (reg_q != cap_data_q);
                last_id_d = cap_id_q;
                cnt_d     = cnt_q + 16'd1;
                ptr_d     = ptr_nxt;
                state_d   = load ? GRANT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cap_id_d   = win_id;
            cap_data_d = lane[win_id];
            gnt_d      = NUM_REQ'(1) << win_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            reg_q      <= RST_VAL;
            cap_id_q   <= '0;
            cap_data_q <= '0;
            ptr_q      <= '0;
            last_id_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            reg_q      <= reg_d;
            cap_id_q   <= cap_id_d;
            cap_data_q <= cap_data_d;
            ptr_q      <= ptr_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign gnt        = gnt_q;
    assign last_id    = last_id_q;
    assign commit_cnt = cnt_q;
    assign busy       = state_q != IDLE;
    assign ERROR      = err_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: scoreboard bench; expected commits are queued at stimulus time and checked per grant.
module tb_shared_reg_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic [7:0]  reg_q;
    logic [1:0]  last_id;
    logic [15:0] commit_cnt;
    logic        busy, error;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_err = 0, n_commit = 0, cyc = 0, gnt_cyc = 0, t0 = 0;
    bit   mon_en = 1'b0, drop_en = 1'b0;

    shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .reg_q(reg_q),
        .last_id(last_id), .commit_cnt(commit_cnt), .busy(busy), .ERROR(error)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin #200000; $display("FAIL watchdog: simulation did not complete"); $fatal(1); end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back('{id: id, data: data});
    endtask

    task automatic wait_q(input bit idle);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && (!idle || !busy)) break;
        end
        chk(idle ? "drain_timeout" : "grant_timeout", 32'(i < 400), 1);
    endtask

    // Requesters drop req once they see their grant, unless holding requests on purpose.
    initial forever begin
        @(negedge clk);
        if (drop_en) req = req & ~gnt;
    end

    initial forever begin
        @(negedge clk);
        while (mon_en && gnt != '0) begin
            automatic bit   have = exp_q.size() != 0;
            automatic exp_t e    = have ? exp_q.pop_front() : '0;
            gnt_cyc = cyc;
            chk("unexpected_grant", 32'(have), 1);
            chk("gnt", 32'(gnt), 32'(4'b0001 << e.id));
            @(negedge clk);
            chk("gnt_pulse", 32'(gnt), 0);
            @(negedge clk);
            chk("reg_q", 32'(reg_q), 32'(e.data));
            @(negedge clk);
            n_commit++;
            chk("last_id", 32'(last_id), 32'(e.id));
            chk("commit_cnt", 32'(commit_cnt), 32'(n_commit));
            chk("ERROR", 32'(error), 0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_reg_q", 32'(reg_q), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_commit_cnt", 32'(commit_cnt), 0);
        chk("rst_ERROR", 32'(error), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_last_id", 32'(last_id), 0);

        // Reset asserted during WRITE must abort without touching reg_q or commit_cnt.
        wdata[15:8] = 8'h77;
        req[1] = 1'b1;
        @(posedge clk); #1;
        chk("mid_gnt", 32'(gnt), 32'h2);
        chk("mid_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("mid_write_gnt", 32'(gnt), 0);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("mid_reg_q", 32'(reg_q), 0);
        chk("mid_commit_cnt", 32'(commit_cnt), 0);
        chk("mid_busy_clr", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef SHARED_REG_FIXED_PRIO_EN
            push(2'd0, 8'h10);
`else
            push(2'(k % 4), 8'(8'h10 + k % 4));
`endif
        end
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        t0 = cyc;
        req = 4'b1111;
        wait_q(1'b0);
        req = '0;
        chk("rr_spacing", 32'(gnt_cyc - t0), 13);
        wait_q(1'b1);

        drop_en = 1'b1;
        push(2'd2, 8'hA5);
        wdata[23:16] = 8'hA5;
        t0 = cyc;
        req[2] = 1'b1;
        wait_q(1'b1);
        chk("gnt_latency", 32'(gnt_cyc - t0), 1);

        push(2'd3, 8'h33);
        wdata[31:24] = 8'h33;
        req[3] = 1'b1;
        wait_q(1'b1);
        push(2'd0, 8'h40);
        push(2'd3, 8'h43);
        wdata[7:0] = 8'h40;
        wdata[31:24] = 8'h43;
        req = 4'b1001;
        wait_q(1'b1);

        push(2'd1, 8'h5A);
        push(2'd2, 8'h5A);
        wdata[15:8] = 8'h5A;
        wdata[23:16] = 8'h5A;
        req = 4'b0110;
        wait_q(1'b1);

        // A request raised and dropped while another transaction is in flight must never be granted.
        push(2'd0, 8'h66);
        wdata[7:0] = 8'h66;
        req[0] = 1'b1;
        wait_q(1'b0);
        req[3] = 1'b1;
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_q(1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("final_commit_cnt", 32'(commit_cnt), 12);
        chk("final_last_id", 32'(last_id), 0);
        chk("final_reg_q", 32'(reg_q), 32'h66);
        chk("final_ERROR", 32'(error), 0);
        chk("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
